// File: rtl/csi2rx_yuv422_10b_b2p.sv
// CSI-2 RX byte-to-pixel unpacker for YUV422 10-bit payloads: folds 32-bit payload
// dwords into 5-byte groups and emits one U/Y0/V/Y1 quad per group with packet framing status.
module csi2rx_yuv422_10b_b2p #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             yuv422_10b_convrn_enable,
    input  logic [31:0]      dw,
    input  logic             dw_vld,
    input  logic             pkt_start,
    input  logic             pkt_end,
    input  logic [1:0]       last_byte_cnt,
    output logic [39:0]      pix_data,
    output logic             pix_vld,
    output logic             pkt_done,
    output logic [CNT_W-1:0] grp_cnt,
    output logic             err_partial,
    output logic             err_seq
);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t           st_q, st_d;
    logic [63:0]      buf_q, buf_d;
    logic [3:0]       lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [39:0]      pix_data_q, pix_data_d;
    logic             pix_vld_q, pix_vld_d;
    logic             pkt_done_q, pkt_done_d;
    logic [CNT_W-1:0] grp_cnt_q, grp_cnt_d;
    logic             err_partial_q, err_partial_d;
    logic             err_seq_q, err_seq_d;

    logic [63:0]      base_buf, merged;
    logic [3:0]       base_lvl, tot;
    logic [CNT_W-1:0] base_cnt;
    logic [2:0]       nb;
    logic             accept;

    // Byte 4 of a group carries the two LSBs of each component, U in the lowest pair.
    function automatic logic [39:0] unpack_grp(input logic [39:0] g);
        logic [7:0] lsb;
        lsb = g[39:32];
        return {g[31:24], lsb[7:6], g[23:16], lsb[5:4], g[15:8], lsb[3:2], g[7:0], lsb[1:0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [31:0] keep_bytes(input logic [31:0] w, input logic [2:0] n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < n) r[8*k +: 8] = w[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        st_d          = st_q;
        buf_d         = buf_q;
        lvl_d         = lvl_q;
        cnt_d         = cnt_q;
        pix_data_d    = pix_data_q;
        pix_vld_d     = 1'b0;
        pkt_done_d    = 1'b0;
        grp_cnt_d     = grp_cnt_q;
        err_partial_d = 1'b0;
        err_seq_d     = 1'b0;
        base_buf      = buf_q;
        base_lvl      = lvl_q;
        base_cnt      = cnt_q;
        accept        = 1'b0;
        nb            = (pkt_end && last_byte_cnt != 2'd0) ? {1'b0, last_byte_cnt} : 3'd4;
        merged        = '0;
        tot           = '0;

        if (!yuv422_10b_convrn_enable) begin
            st_d       = IDLE;
            buf_d      = '0;
            lvl_d      = '0;
            cnt_d      = '0;
            pix_data_d = '0;
        end else if (dw_vld) begin
            // A pkt_start always opens a fresh packet, aborting any open one.
            if (pkt_start) begin
                accept   = 1'b1;
                base_buf = '0;
                base_lvl = '0;
                base_cnt = '0;
                st_d     = pkt_end ? IDLE : IN_PKT;
                if (st_q == IN_PKT) err_seq_d = 1'b1;
            end else if (st_q == IN_PKT) begin
                accept = 1'b1;
                if (pkt_end) st_d = IDLE;
            end else begin
                err_seq_d = 1'b1;
            end

            if (accept) begin
                merged = base_buf | ({32'b0, keep_bytes(dw, nb)} << {base_lvl, 3'b000});
                tot    = base_lvl + {1'b0, nb};
                if (tot >= 4'd5) begin
                    pix_data_d = unpack_grp(merged[39:0]);
                    pix_vld_d  = 1'b1;
                    merged     = merged >> 40;
                    tot        = tot - 4'd5;
                    base_cnt   = sat_inc(base_cnt);
                end
                if (pkt_end) begin
                    err_partial_d = (tot != 4'd0);
                    pkt_done_d    = 1'b1;
                    grp_cnt_d     = base_cnt;
                    buf_d         = '0;
                    lvl_d         = '0;
                    cnt_d         = '0;
                end else begin
                    buf_d = merged;
                    lvl_d = tot;
                    cnt_d = base_cnt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q          <= IDLE;
            buf_q         <= '0;
            lvl_q         <= '0;
            cnt_q         <= '0;
            pix_data_q    <= '0;
            pix_vld_q     <= 1'b0;
            pkt_done_q    <= 1'b0;
            grp_cnt_q     <= '0;
            err_partial_q <= 1'b0;
            err_seq_q     <= 1'b0;
        end else begin
            st_q          <= st_d;
            buf_q         <= buf_d;
            lvl_q         <= lvl_d;
            cnt_q         <= cnt_d;
            pix_data_q    <= pix_data_d;
            pix_vld_q     <= pix_vld_d;
            pkt_done_q    <= pkt_done_d;
            grp_cnt_q     <= grp_cnt_d;
            err_partial_q <= err_partial_d;
            err_seq_q     <= err_seq_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_vld     = pix_vld_q;
    assign pkt_done    = pkt_done_q;
    assign grp_cnt     = grp_cnt_q;
    assign err_partial = err_partial_q;
    assign err_seq     = err_seq_q;

endmodule
